// File: rtl/tiny_soc_mem_pkg.sv
// Shared types for the tiny SoC memory arbiter: word/address/strobe types,
// the requester identity, the registered response record and the
// strobe-to-bitmask expansion used to drive the SRAM write mask.
package tiny_soc_mem_pkg;

  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [31:0]       addr_t;
  typedef logic [STRB_W-1:0] strb_t;

  typedef enum logic {
    REQ_INSTR = 1'b0,
    REQ_DATA  = 1'b1
  } requester_e;

  typedef struct packed {
    logic       valid;
    requester_e owner;
    logic       err;
  } resp_t;

  // Each strobe bit enables one byte lane of the SRAM word.
  function automatic data_t strb_to_wmask(input strb_t strb);
    data_t mask;
    for (int i = 0; i < STRB_W; i++) begin
      mask[i*8 +: 8] = {8{strb[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/tiny_soc_mem_arb_rr.sv
// Two-way round-robin picker for the instruction and data requesters.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   req[1:0]  requests, bit 0 = instruction, bit 1 = data
//   gnt[1:0]  one-hot grant, combinational in the accept cycle, 0 in reset
// last_winner resets to the instruction side, so data wins the first tie.
module tiny_soc_mem_arb_rr
  import tiny_soc_mem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  requester_e last_winner;

  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      if (req == 2'b11) begin
        gnt = (last_winner == REQ_INSTR) ? 2'b10 : 2'b01;
      end else begin
        gnt = req;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_winner <= REQ_INSTR;
    end else if (gnt[1]) begin
      last_winner <= REQ_DATA;
    end else if (gnt[0]) begin
      last_winner <= REQ_INSTR;
    end
  end

endmodule

// File: rtl/tiny_soc_mem_arbiter.sv
// Shares one single-port 32-bit SRAM between the CPU instruction and data
// ports. One requester is granted per cycle (round robin on ties), in-window
// requests are forwarded to the SRAM in the grant cycle, out-of-window
// requests are answered with an error, and every grant gets a one-cycle
// response (rvalid, rdata, err) in the following cycle.
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   instr_* / data_*             req/gnt/addr/wdata/strb/we in, rvalid/rdata/err out
//   sram_req_o .. sram_wmask_o   SRAM command, driven combinationally on a hit grant
//   sram_rdata_i                 SRAM read data, one cycle after sram_req_o
// Optional build macro TINY_SOC_MEM_ARB_PERF_EN adds perf_conflicts_o and
// perf_oob_o, saturating counters of conflict cycles and window misses.
module tiny_soc_mem_arbiter
  import tiny_soc_mem_pkg::*;
#(
  parameter int unsigned Depth    = 2**20,
  parameter addr_t       BaseAddr = 32'h8000_0000
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     instr_req_i,
  output logic                     instr_gnt_o,
  input  addr_t                    instr_addr_i,
  input  data_t                    instr_wdata_i,
  input  strb_t                    instr_strb_i,
  input  logic                     instr_we_i,
  output logic                     instr_rvalid_o,
  output data_t                    instr_rdata_o,
  output logic                     instr_err_o,
  input  logic                     data_req_i,
  output logic                     data_gnt_o,
  input  addr_t                    data_addr_i,
  input  data_t                    data_wdata_i,
  input  strb_t                    data_strb_i,
  input  logic                     data_we_i,
  output logic                     data_rvalid_o,
  output data_t                    data_rdata_o,
  output logic                     data_err_o,
  output logic                     sram_req_o,
  output logic                     sram_we_o,
  output logic [$clog2(Depth)-1:0] sram_addr_o,
  output data_t                    sram_wdata_o,
  output data_t                    sram_wmask_o,
`ifdef TINY_SOC_MEM_ARB_PERF_EN
  input  data_t                    sram_rdata_i,
  output logic [31:0]              perf_conflicts_o,
  output logic [31:0]              perf_oob_o
`else
  input  data_t                    sram_rdata_i
`endif
);

  localparam int AW = $clog2(Depth);

  logic [1:0]  req_p0;
  logic [1:0]  gnt_p0;
  logic        take_p0;
  requester_e  sel_p0;
  logic [29:0] waddr_p0;
  logic [29:0] woff_p0;
  data_t       wdata_p0;
  strb_t       strb_p0;
  logic        we_p0;
  logic        hit_p0;
  logic        go_p0;

  resp_t       resp_p1;
  logic        rd_p1;
  logic        live_p1;
  logic        rdata_ok_p1;

  // Byte-offset bits do not select anything in a word-wide SRAM.
  logic        unused_addr_lsbs;
  assign unused_addr_lsbs = ^{instr_addr_i[1:0], data_addr_i[1:0]};

  // ---- Stage p0: arbitration, window decode, SRAM drive ----
  assign req_p0 = {data_req_i, instr_req_i};

  tiny_soc_mem_arb_rr u_rr (
    .clk (clk_i),
    .rst (rst_i),
    .req (req_p0),
    .gnt (gnt_p0)
  );

  assign instr_gnt_o = gnt_p0[0];
  assign data_gnt_o  = gnt_p0[1];
  assign take_p0     = |gnt_p0;
  assign sel_p0      = gnt_p0[1] ? REQ_DATA : REQ_INSTR;

  always_comb begin
    if (sel_p0 == REQ_DATA) begin
      waddr_p0 = data_addr_i[31:2];
      wdata_p0 = data_wdata_i;
      strb_p0  = data_strb_i;
      we_p0    = data_we_i;
    end else begin
      waddr_p0 = instr_addr_i[31:2];
      wdata_p0 = instr_wdata_i;
      strb_p0  = instr_strb_i;
      we_p0    = instr_we_i;
    end
  end

  // Word-granular unsigned offset: addresses below BaseAddr wrap to a huge
  // offset and fall outside the window like any other miss.
  assign woff_p0 = waddr_p0 - BaseAddr[31:2];
  assign hit_p0  = ({2'b00, woff_p0} < Depth);
  assign go_p0   = take_p0 & hit_p0;

  // SRAM command lines sit at zero whenever no in-window grant is present.
  always_comb begin
    sram_req_o   = go_p0;
    sram_we_o    = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = '0;
    sram_wmask_o = '0;
    if (go_p0) begin
      sram_we_o    = we_p0;
      sram_addr_o  = woff_p0[AW-1:0];
      sram_wdata_o = wdata_p0;
      sram_wmask_o = strb_to_wmask(strb_p0);
    end
  end

  // ---- Stage p1: response register ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_p1 <= '0;
      rd_p1   <= 1'b0;
    end else begin
      resp_p1.valid <= take_p0;
      resp_p1.owner <= sel_p0;
      resp_p1.err   <= take_p0 & ~hit_p0;
      rd_p1         <= ~we_p0;
    end
  end

  // Reset masks the response in the same cycle, so a read already issued to
  // the SRAM never reaches a requester.
  assign live_p1     = resp_p1.valid & ~rst_i;
  assign rdata_ok_p1 = live_p1 & ~resp_p1.err & rd_p1;

  assign instr_rvalid_o = live_p1 & (resp_p1.owner == REQ_INSTR);
  assign data_rvalid_o  = live_p1 & (resp_p1.owner == REQ_DATA);
  assign instr_err_o    = instr_rvalid_o & resp_p1.err;
  assign data_err_o     = data_rvalid_o & resp_p1.err;
  assign instr_rdata_o  = (rdata_ok_p1 && resp_p1.owner == REQ_INSTR) ? sram_rdata_i : '0;
  assign data_rdata_o   = (rdata_ok_p1 && resp_p1.owner == REQ_DATA) ? sram_rdata_i : '0;

`ifdef TINY_SOC_MEM_ARB_PERF_EN
  logic [31:0] conflicts_p1;
  logic [31:0] oob_p1;

  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic en);
    return (en && val != 32'hFFFF_FFFF) ? val + 32'd1 : val;
  endfunction

  // ---- Stage p1: performance counters ----
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      conflicts_p1 <= '0;
      oob_p1       <= '0;
    end else begin
      conflicts_p1 <= sat_inc(conflicts_p1, &req_p0);
      oob_p1       <= sat_inc(oob_p1, take_p0 & ~hit_p0);
    end
  end

  assign perf_conflicts_o = conflicts_p1;
  assign perf_oob_o       = oob_p1;
`endif

endmodule
